// File: rtl/c2p_ctrl_pkg.sv
// Shared constants for the c2p AXI4-Lite control block: register offsets,
// STATUS bit positions, response codes and the stream state enum.
package c2p_ctrl_pkg;
  localparam int REG_MAP    = 'h0;
  localparam int REG_CTRL   = 'h4;
  localparam int REG_STATUS = 'h8;
  localparam int REG_CLEAR  = 'hC;

  localparam int ST_BUSY = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVF  = 16;
  localparam int ST_REJ  = 17;
  localparam int ST_DONE = 18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
endpackage

// File: rtl/c2p_axil_ctrl_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and c2p_axil_ctrl (slave).
interface c2p_axil_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid, s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid, s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid, s_bready;
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid, s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid, s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
           s_rresp, s_rvalid
  );
  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
           s_rresp, s_rvalid
  );
endinterface

// File: rtl/c2p_ctrl_fifo.sv
// Synchronous map-word FIFO; pointers carry a wrap bit so full/empty need no extra state.
module c2p_ctrl_fifo #(
  parameter int  DATA_W     = 32,
  parameter int  FIFO_DEPTH = 16,
  localparam int PW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [PW-1:0]     o_count,
  output logic              o_full,
  output logic              o_empty
);
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic              w_push_ok, w_pop_ok;

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
  assign o_data    = r_mem[r_rptr[PW-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[PW-2:0]] <= i_data;
  end
endmodule

// File: rtl/c2p_axil_ctrl.sv
// AXI4-Lite register block that batches map words and streams them into the c2p core.
// Optional C2P_CTRL_IRQ_EN adds a sticky done flag (STATUS[18], CLEAR bit1) driving irq.
module c2p_axil_ctrl
  import c2p_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              sys_clock,
  input  logic              reset,
  c2p_axil_ctrl_if.slave    s_axil,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
`ifdef C2P_CTRL_IRQ_EN
  , output logic            irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  logic              r_live, r_aw_full, r_w_full, r_wstrb0, r_bvalid, r_rvalid;
  logic              r_ovf, r_rej;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_status, w_head;
  logic [1:0]        r_bresp, w_resp;
  logic [CW-1:0]     r_rem, w_count;
  logic              w_exec, w_push, w_start, w_set_ovf, w_set_rej, w_clr_err;
  logic              w_full, w_empty, w_hs, w_unused;
`ifdef C2P_CTRL_IRQ_EN
  logic              r_done, w_clr_done;
  assign irq = r_done;
`endif

  // r_live holds the readies low through reset so every output idles at 0
  assign s_axil.s_awready = r_live & ~r_aw_full & ~r_bvalid;
  assign s_axil.s_wready  = r_live & ~r_w_full & ~r_bvalid;
  assign s_axil.s_bvalid  = r_bvalid;
  assign s_axil.s_bresp   = r_bresp;
  assign s_axil.s_arready = r_live & ~r_rvalid;
  assign s_axil.s_rvalid  = r_rvalid;
  assign s_axil.s_rdata   = r_rdata;
  assign s_axil.s_rresp   = RESP_OKAY;

  assign m_valid  = (r_state == STREAM);
  assign m_data   = m_valid ? w_head : '0;
  assign m_last   = m_valid & (r_rem == CW'(1));
  assign w_hs     = m_valid & m_ready;
  assign w_exec   = r_aw_full & r_w_full & ~r_bvalid;
  assign w_unused = ^{s_axil.s_wstrb[DATA_W/8-1:1], w_empty};

  c2p_ctrl_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(sys_clock), .rst(reset), .i_push(w_push), .i_data(r_wdata), .i_pop(w_hs),
    .o_data(w_head), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
  );

  always_comb begin
    w_push = 1'b0; w_start = 1'b0; w_set_ovf = 1'b0; w_set_rej = 1'b0;
    w_clr_err = 1'b0; w_resp = RESP_OKAY;
`ifdef C2P_CTRL_IRQ_EN
    w_clr_done = 1'b0;
`endif
    if (w_exec) begin
      case (r_awaddr)
        ADDR_W'(REG_MAP): begin
          if (w_full || m_valid) begin
            w_resp    = RESP_SLVERR;
            w_set_ovf = w_full;
            w_set_rej = m_valid;
          end else begin
            w_push = 1'b1;
          end
        end
        ADDR_W'(REG_CTRL):  w_start = r_wstrb0 & r_wdata[0] & ~m_valid & (w_count != '0);
        ADDR_W'(REG_CLEAR): begin
          w_clr_err = r_wstrb0 & r_wdata[0];
`ifdef C2P_CTRL_IRQ_EN
          w_clr_done = r_wstrb0 & r_wdata[1];
`endif
        end
        default: w_resp = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[CW-1:0]      = w_count;
    w_status[ST_BUSY]     = m_valid;
    w_status[ST_FULL]     = w_full;
    w_status[ST_OVF]      = r_ovf;
    w_status[ST_REJ]      = r_rej;
`ifdef C2P_CTRL_IRQ_EN
    w_status[ST_DONE]     = r_done;
`endif
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;    r_live  <= 1'b0; r_rem    <= '0;
      r_aw_full <= 1'b0;  r_awaddr <= '0;
      r_w_full  <= 1'b0;  r_wdata  <= '0;  r_wstrb0 <= 1'b0;
      r_bvalid  <= 1'b0;  r_bresp  <= RESP_OKAY;
      r_rvalid  <= 1'b0;  r_rdata  <= '0;
      r_ovf     <= 1'b0;  r_rej    <= 1'b0;
`ifdef C2P_CTRL_IRQ_EN
      r_done    <= 1'b0;
`endif
    end else begin
      r_live <= 1'b1;
      if (s_axil.s_awvalid && s_axil.s_awready) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s_axil.s_awaddr;
      end
      if (s_axil.s_wvalid && s_axil.s_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_axil.s_wdata;
        r_wstrb0 <= s_axil.s_wstrb[0];
      end
      if (w_exec) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_resp;
      end else if (r_bvalid && s_axil.s_bready) begin
        r_bvalid <= 1'b0;
      end

      if (s_axil.s_arvalid && s_axil.s_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= (s_axil.s_araddr == ADDR_W'(REG_STATUS)) ? w_status : '0;
      end else if (r_rvalid && s_axil.s_rready) begin
        r_rvalid <= 1'b0;
      end

      case (r_state)
        IDLE: if (w_start) begin
          r_state <= STREAM;
          r_rem   <= w_count;
        end
        STREAM: if (w_hs) begin
          r_rem <= r_rem - CW'(1);
          if (r_rem == CW'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // sets are OR'd after the clear mask so a coincident set wins
      r_ovf <= (r_ovf & ~w_clr_err) | w_set_ovf;
      r_rej <= (r_rej & ~w_clr_err) | w_set_rej;
`ifdef C2P_CTRL_IRQ_EN
      r_done <= (r_done & ~w_clr_done) | (w_hs & m_last);
`endif
    end
  end
endmodule

// File: doc/c2p_axil_ctrl.md
Name: c2p_axil_ctrl

Overview:
- AXI4-Lite slave register block that feeds the cartesian-to-polar (c2p) conversion stage.
- Software writes map words into offset 0x0; each write is buffered in a FIFO.
- A write of 1 to offset 0x4 (inp1_valid) releases the buffered batch as a valid/ready stream into the c2p core.
- Sits between the AXI interconnect (SLAVE1 window, base 0x0000_0000) and the c2p input.

Parameters:
- DATA_W, 32, AXI data width and map-word width
- ADDR_W, 4, byte-address bits decoded (registers 0x0-0xC)
- FIFO_DEPTH, 16, map-word buffer depth, power of two

Ports:
- sys_clock  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_W  write data
- s_wstrb  in  DATA_W/8  write strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_W  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_W  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- m_data  out  DATA_W  map word to c2p
- m_valid  out  1  stream valid
- m_last  out  1  final word of batch
- m_ready  in  1  c2p ready

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; overflow and reject sticky bits 0.
- Write channel:
  - AW and W are accepted independently: each ready is high while its holding register is empty and bvalid=0.
  - The write executes in the cycle after both are held.
  - bvalid rises in the same cycle as the execute and holds until bready.
  - Only one write is outstanding at a time.
  - wstrb is ignored except on 0x4 and 0xC, where bit0 requires wstrb[0].
- Read channel:
  - arready=1 when rvalid=0.
  - rvalid asserts one cycle after the AR handshake and holds until rready.
  - rresp=OKAY.
- Register map:
  - 0x0 MAP (WO): push wdata into the FIFO. If the FIFO is full, or state=STREAM: drop the word, bresp=SLVERR, set overflow (full) or reject (STREAM). Otherwise bresp=OKAY. Reads return 0.
  - 0x4 CTRL (WO): wdata[0]=1 in IDLE with FIFO count>0 latches batch_len=count and enters STREAM. With count=0 or state=STREAM it has no effect; bresp=OKAY. Writing 0 has no effect.
  - 0x8 STATUS (RO): [4:0] count, [8] busy(STREAM), [9] full, [16] overflow, [17] reject.
  - 0xC CLEAR (WO): bit0 clears overflow and reject. Same-cycle set and clear: set wins.
  - Unmapped writes: bresp=SLVERR, no side effect.
- State machine:
  - IDLE -> STREAM on a valid CTRL start.
  - STREAM: m_valid=1 with m_data=FIFO head; pop on m_valid&m_ready; m_last=1 when remaining=1.
  - STREAM -> IDLE in the cycle after the last handshake.
- Stream rules:
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
  - First-word latency: m_valid rises in the cycle after the B-execute cycle of the CTRL write.
- FIFO: pointers log2(FIFO_DEPTH)+1 bits wide with wrap bit; full when MSBs differ and low bits are equal.
- Reset mid-batch: the batch is discarded and m_valid drops asynchronously.

Optional Feature:
- Macro: C2P_CTRL_IRQ_EN.
- When defined:
  - Output irq (1 bit) is added.
  - A sticky done flag sets on the final m_last handshake and drives irq as a level.
  - The flag is visible at STATUS[18] and cleared by CLEAR bit1.
  - Same-cycle set and clear: set wins.
- When undefined: no irq port; STATUS[18] reads 0; CLEAR bit1 is ignored.

Decomposition:
- Package c2p_ctrl_pkg holds:
  - register offsets (REG_MAP, REG_CTRL, REG_STATUS, REG_CLEAR)
  - STATUS bit positions
  - resp constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10)
  - state enum {IDLE, STREAM}
- One sub-module, c2p_ctrl_fifo: synchronous FIFO with push, pop, count, full and empty, parameterised by DATA_W and FIFO_DEPTH.

Test Plan:
- Write MAP=6, MAP=7, then CTRL=1 with m_ready=1 -> STATUS count reads 2 before CTRL; stream emits 6 then 7 with m_last on 7 only; busy clears the cycle after.
- m_ready held 0 for 5 cycles mid-batch -> m_data=7 and m_last=1 held stable; no loss or duplication.
- 17 MAP writes (FIFO_DEPTH=16) -> 17th returns bresp=SLVERR; STATUS[16]=1, count=16; CLEAR=1 -> STATUS[16]=0.
- MAP write during STREAM -> SLVERR and STATUS[17]=1; CTRL=1 with an empty FIFO -> no m_valid, bresp=OKAY.
- AW issued 3 cycles before W, and W before AW -> exactly one B per write; bvalid held under bready=0 for 4 cycles; no second accept until B completes.
- reset asserted during STREAM after 1 of 3 words -> m_valid=0 immediately; STATUS reads 0 after release. With C2P_CTRL_IRQ_EN: irq=1 after the last word; CLEAR=2 -> irq=0.
